// File: rtl/arm_multicycle_controller.sv
// Multi-cycle ARM control FSM: FETCH/DECODE/EXECUTE sequencing with NZCV condition evaluation.
// Outputs are Moore-decoded from the current state and the IR; write strobes are held low during reset.
module arm_multicycle_controller #(
    parameter bit          ENABLE_COND = 1'b1,
    parameter bit          ENABLE_BL   = 1'b1,
    parameter bit          ENABLE_BX   = 1'b1,
    parameter logic [3:0]  FLAG_RESET  = 4'b0000
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic [1:0]  RegSrc,
    output logic        LinkWrite,
    output logic        BX_ctrl,
    output logic [3:0]  flags_o,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        BXEX     = 4'd10
    } state_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_MOV = 4'b0100;

    state_t     state_q, state_d;
    logic [3:0] nzcv_q, nzcv_d;

    logic [1:0] op;
    logic [3:0] cmd, cond;
    logic       i_bit, s_bit, u_bit, is_bx, is_cmp;
    logic       cond_ok, cmd_ok, is_arith;
    logic [3:0] alu_dp;
    logic       n, z, c, v;
    logic       pc_wr, ir_wr, mem_wr, reg_wr, link_wr, bx_sel;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign i_bit        = Instr[25];
    assign cmd          = Instr[24:21];
    assign s_bit        = Instr[20];
    assign u_bit        = Instr[23];
    assign cond         = ENABLE_COND ? Instr[31:28] : 4'b1110;
    assign is_bx        = ENABLE_BX && (Instr[27:4] == 24'h12FFF1);
    assign is_cmp       = (cmd == CMD_CMP);
    assign unused_instr = ^Instr[3:0];
    assign {n, z, c, v} = nzcv_q;

    // cond 1111 is treated as a failing condition, so it falls through to FETCH
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = z;
            4'h1: cond_ok = !z;
            4'h2: cond_ok = c;
            4'h3: cond_ok = !c;
            4'h4: cond_ok = n;
            4'h5: cond_ok = !n;
            4'h6: cond_ok = v;
            4'h7: cond_ok = !v;
            4'h8: cond_ok = c && !z;
            4'h9: cond_ok = !c || z;
            4'hA: cond_ok = (n == v);
            4'hB: cond_ok = (n != v);
            4'hC: cond_ok = !z && (n == v);
            4'hD: cond_ok = z || (n != v);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_dp   = ALU_ADD;
        cmd_ok   = 1'b1;
        is_arith = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_dp = ALU_ADD; is_arith = 1'b1; end
            CMD_SUB: begin alu_dp = ALU_SUB; is_arith = 1'b1; end
            CMD_CMP: begin alu_dp = ALU_SUB; is_arith = 1'b1; end
            CMD_AND: alu_dp = ALU_AND;
            CMD_ORR: alu_dp = ALU_ORR;
            CMD_MOV: alu_dp = ALU_MOV;
            default: cmd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= FETCH;
            nzcv_q  <= FLAG_RESET;
        end else begin
            state_q <= state_d;
            nzcv_q  <= nzcv_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        nzcv_d     = nzcv_q;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        link_wr    = 1'b0;
        bx_sel     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        case (state_q)
            FETCH: begin
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (!cond_ok)                  state_d = FETCH;
                else if (op == 2'b01)          state_d = MEMADR;
                else if (is_bx)                state_d = BXEX;
                else if (op == 2'b10)          state_d = BRANCH;
                else if (op == 2'b00 && cmd_ok) state_d = i_bit ? EXECI : EXECR;
                else                           state_d = FETCH;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b01;
                ALUControl = u_bit ? ALU_ADD : ALU_SUB;
                state_d    = s_bit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_wr    = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_wr = 1'b1;
                RegSrc = 2'b10;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_dp;
                state_d    = is_cmp ? FETCH : ALUWB;
                // logical ops keep the previous carry/overflow
                if (s_bit || is_cmp) begin
                    nzcv_d[3:2] = ALUFlags[3:2];
                    if (is_arith) nzcv_d[1:0] = ALUFlags[1:0];
                end
            end
            ALUWB: reg_wr = 1'b1;
            BRANCH: begin
                RegSrc    = 2'b01;
                ImmSrc    = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_wr     = 1'b1;
                link_wr   = ENABLE_BL && Instr[24];
            end
            BXEX: begin
                bx_sel = 1'b1;
                pc_wr  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign PCWrite   = pc_wr   & RESET;
    assign IRWrite   = ir_wr   & RESET;
    assign MemWrite  = mem_wr  & RESET;
    assign RegWrite  = reg_wr  & RESET;
    assign LinkWrite = link_wr & RESET;
    assign BX_ctrl   = bx_sel  & RESET;
    assign flags_o   = nzcv_q;
    assign state_o   = state_q;

endmodule
